// File: rtl/ld_st_issue_queue_pkg.sv
// Shared definitions for the load/store issue queue: opcode encodings,
// default widths, the queue entry layout and a readiness helper.
package ld_st_issue_queue_pkg;

    localparam int LSQ_DEPTH      = 4;
    localparam int LSQ_TAG_WIDTH  = 6;
    localparam int LSQ_DATA_WIDTH = 32;

    localparam logic OPC_LW = 1'b0;
    localparam logic OPC_SW = 1'b1;

    // One queue slot at the default widths.
    typedef struct packed {
        logic                      valid;
        logic                      opcode;
        logic [LSQ_TAG_WIDTH-1:0]  rs_tag;
        logic [LSQ_DATA_WIDTH-1:0] rs_data;
        logic                      rs_ready;
        logic [LSQ_TAG_WIDTH-1:0]  rt_tag;
        logic [LSQ_DATA_WIDTH-1:0] rt_data;
        logic                      rt_ready;
        logic [LSQ_DATA_WIDTH-1:0] imm;
        logic [LSQ_TAG_WIDTH-1:0]  rd_tag;
    } lsq_entry_t;

    // Loads only need the base register; stores also need the store data.
    function automatic logic entry_ready(input logic opcode,
                                         input logic rs_ready,
                                         input logic rt_ready);
        return rs_ready && ((opcode == OPC_LW) || rt_ready);
    endfunction

endpackage

// File: rtl/ld_st_issue_queue_snoop.sv
// One source operand of one queue slot: latches the value at dispatch
// (taking a same-cycle CDB hit as a bypass) and later captures the CDB
// broadcast whose tag matches while the operand is still missing.
module lsq_operand_snoop #(
    parameter int TAG_WIDTH  = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic [TAG_WIDTH-1:0]  i_load_tag,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic                  i_load_valid,
    input  logic                  i_entry_valid,
    input  logic                  i_cdb_valid,
    input  logic [TAG_WIDTH-1:0]  i_cdb_tag,
    input  logic [DATA_WIDTH-1:0] i_cdb_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_ready
);

    logic [TAG_WIDTH-1:0]  r_tag;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_ready;
    logic                  w_load_hit;
    logic                  w_snoop_hit;

    assign w_load_hit  = i_cdb_valid && (i_cdb_tag == i_load_tag);
    assign w_snoop_hit = i_entry_valid && !r_ready && i_cdb_valid && (i_cdb_tag == r_tag);

    // Operand capture: dispatch write (with bypass) or CDB snoop while waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag   <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
        end else if (i_clear) begin
            r_ready <= 1'b0;
        end else if (i_load) begin
            r_tag <= i_load_tag;
            if (i_load_valid) begin
                r_data  <= i_load_data;
                r_ready <= 1'b1;
            end else if (w_load_hit) begin
                r_data  <= i_cdb_data;
                r_ready <= 1'b1;
            end else begin
                r_data  <= i_load_data;
                r_ready <= 1'b0;
            end
        end else if (w_snoop_hit) begin
            r_data  <= i_cdb_data;
            r_ready <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_ready = r_ready;

endmodule

// File: rtl/ld_st_issue_queue.sv
// In-order load/store issue queue. Holds dispatched LW/SW instructions in a
// circular buffer, waits for their operands via CDB snooping and hands the
// oldest ready one to the memory execution unit as a registered bundle.
module ld_st_issue_queue
    import ld_st_issue_queue_pkg::*;
#(
    parameter int DEPTH      = LSQ_DEPTH,
    parameter int TAG_WIDTH  = LSQ_TAG_WIDTH,
    parameter int DATA_WIDTH = LSQ_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  dispatch_valid,
    input  logic                  dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]  dispatch_rs_tag,
    input  logic [DATA_WIDTH-1:0] dispatch_rs_data,
    input  logic                  dispatch_rs_valid,
    input  logic [TAG_WIDTH-1:0]  dispatch_rt_tag,
    input  logic [DATA_WIDTH-1:0] dispatch_rt_data,
    input  logic                  dispatch_rt_valid,
    input  logic [DATA_WIDTH-1:0] dispatch_imm,
    input  logic [TAG_WIDTH-1:0]  dispatch_rd_tag,
    output logic                  queue_full,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output logic                  issue_req,
    input  logic                  issue_grant,
    output logic                  issueblk_done,
    output logic [DATA_WIDTH-1:0] issueque_rs_data,
    output logic [DATA_WIDTH-1:0] issueque_rt_data,
    output logic [DATA_WIDTH-1:0] issueque_imm,
    output logic                  issueque_opcode,
    output logic [TAG_WIDTH-1:0]  issueque_rd_tag
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    // mem_data_exec_unit layout: {done, opcode, rd_tag, imm, rt_data, rs_data}
    localparam int RS_LO    = 0;
    localparam int RT_LO    = DATA_WIDTH;
    localparam int IMM_LO   = 2 * DATA_WIDTH;
    localparam int RD_LO    = 3 * DATA_WIDTH;
    localparam int OPC_BIT  = 3 * DATA_WIDTH + TAG_WIDTH;
    localparam int DONE_BIT = OPC_BIT + 1;
    localparam int BUNDLE_W = DONE_BIT + 1;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [DEPTH-1:0]      r_valid;
    logic [DEPTH-1:0]      r_opcode;
    logic [DATA_WIDTH-1:0] r_imm    [DEPTH];
    logic [TAG_WIDTH-1:0]  r_rd_tag [DEPTH];
    logic [BUNDLE_W-1:0]   r_mem_data_exec_unit;

    logic [DATA_WIDTH-1:0] w_rs_data [DEPTH];
    logic [DATA_WIDTH-1:0] w_rt_data [DEPTH];
    logic [DEPTH-1:0]      w_rs_ready;
    logic [DEPTH-1:0]      w_rt_ready;
    logic [DEPTH-1:0]      w_load;
    logic                  w_full;
    logic                  w_dispatch;
    logic                  w_issue;
    logic                  w_rt_load_valid;
    logic [BUNDLE_W-1:0]   w_bundle_next;

    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign queue_full = w_full;
    assign issue_req  = r_valid[r_head] &&
                        entry_ready(r_opcode[r_head], w_rs_ready[r_head], w_rt_ready[r_head]);

    // Flush wins over both dispatch and issue in the same cycle.
    assign w_dispatch = dispatch_valid && !w_full && !flush;
    assign w_issue    = issue_req && issue_grant && !flush;

    // A load never waits on rt, so its rt slot is treated as present.
    assign w_rt_load_valid = dispatch_rt_valid || (dispatch_opcode == OPC_LW);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_load[gi] = w_dispatch && (r_tail == PTR_W'(gi));

            lsq_operand_snoop #(
                .TAG_WIDTH  (TAG_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_rs_snoop (
                .clk           (clk),
                .rst_n         (rst_n),
                .i_clear       (flush),
                .i_load        (w_load[gi]),
                .i_load_tag    (dispatch_rs_tag),
                .i_load_data   (dispatch_rs_data),
                .i_load_valid  (dispatch_rs_valid),
                .i_entry_valid (r_valid[gi]),
                .i_cdb_valid   (cdb_valid),
                .i_cdb_tag     (cdb_tag),
                .i_cdb_data    (cdb_data),
                .o_data        (w_rs_data[gi]),
                .o_ready       (w_rs_ready[gi])
            );

            lsq_operand_snoop #(
                .TAG_WIDTH  (TAG_WIDTH),
                .DATA_WIDTH (DATA_WIDTH)
            ) u_rt_snoop (
                .clk           (clk),
                .rst_n         (rst_n),
                .i_clear       (flush),
                .i_load        (w_load[gi]),
                .i_load_tag    (dispatch_rt_tag),
                .i_load_data   (dispatch_rt_data),
                .i_load_valid  (w_rt_load_valid),
                .i_entry_valid (r_valid[gi]),
                .i_cdb_valid   (cdb_valid),
                .i_cdb_tag     (cdb_tag),
                .i_cdb_data    (cdb_data),
                .o_data        (w_rt_data[gi]),
                .o_ready       (w_rt_ready[gi])
            );
        end
    endgenerate

    // Static payload of each slot, written once at dispatch (no reset needed).
    always_ff @(posedge clk) begin
        if (w_dispatch) begin
            r_opcode[r_tail] <= dispatch_opcode;
            r_imm[r_tail]    <= dispatch_imm;
            r_rd_tag[r_tail] <= dispatch_rd_tag;
        end
    end

    // Queue bookkeeping: pointers, occupancy and per-slot valid bits.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_dispatch) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_issue) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_dispatch, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_bundle_next = {1'b1, r_opcode[r_head], r_rd_tag[r_head], r_imm[r_head],
                            w_rt_data[r_head], w_rs_data[r_head]};

    // Issue bundle register: loads on a granted issue, otherwise holds with done low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_data_exec_unit <= '0;
        end else if (w_issue) begin
            r_mem_data_exec_unit <= w_bundle_next;
        end else begin
            r_mem_data_exec_unit[DONE_BIT] <= 1'b0;
        end
    end

    assign issueblk_done    = r_mem_data_exec_unit[DONE_BIT];
    assign issueque_opcode  = r_mem_data_exec_unit[OPC_BIT];
    assign issueque_rd_tag  = r_mem_data_exec_unit[RD_LO  +: TAG_WIDTH];
    assign issueque_imm     = r_mem_data_exec_unit[IMM_LO +: DATA_WIDTH];
    assign issueque_rt_data = r_mem_data_exec_unit[RT_LO  +: DATA_WIDTH];
    assign issueque_rs_data = r_mem_data_exec_unit[RS_LO  +: DATA_WIDTH];

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Self-checking bench for ld_st_issue_queue: a scoreboard queue holds the
// bundle expected for every accepted instruction, and a monitor compares it
// against each issueblk_done pulse.
module tb_ld_st_issue_queue;
    import ld_st_issue_queue_pkg::*;

    localparam int TW = 6;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush;
    logic          dispatch_valid, dispatch_opcode, dispatch_rs_valid, dispatch_rt_valid;
    logic [TW-1:0] dispatch_rs_tag, dispatch_rt_tag, dispatch_rd_tag;
    logic [DW-1:0] dispatch_rs_data, dispatch_rt_data, dispatch_imm;
    logic          queue_full, cdb_valid, issue_req, issue_grant, issueblk_done;
    logic [TW-1:0] cdb_tag, issueque_rd_tag;
    logic [DW-1:0] cdb_data, issueque_rs_data, issueque_rt_data, issueque_imm;
    logic          issueque_opcode;

    lsq_entry_t sb[$];
    lsq_entry_t mon_e;
    int n_vec = 0;
    int n_err = 0;

    ld_st_issue_queue #(.DEPTH(DEPTH), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
        .dispatch_rs_tag(dispatch_rs_tag), .dispatch_rs_data(dispatch_rs_data),
        .dispatch_rs_valid(dispatch_rs_valid), .dispatch_rt_tag(dispatch_rt_tag),
        .dispatch_rt_data(dispatch_rt_data), .dispatch_rt_valid(dispatch_rt_valid),
        .dispatch_imm(dispatch_imm), .dispatch_rd_tag(dispatch_rd_tag),
        .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_data(cdb_data), .issue_req(issue_req), .issue_grant(issue_grant),
        .issueblk_done(issueblk_done), .issueque_rs_data(issueque_rs_data),
        .issueque_rt_data(issueque_rt_data), .issueque_imm(issueque_imm),
        .issueque_opcode(issueque_opcode), .issueque_rd_tag(issueque_rd_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every issue pulse is matched against the oldest expected bundle.
    always @(negedge clk) begin
        if (issueblk_done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_issue: rd_tag=%0d rs=%h with empty scoreboard",
                         issueque_rd_tag, issueque_rs_data);
            end else begin
                mon_e = sb.pop_front();
                n_vec++;
                if (issueque_rs_data !== mon_e.rs_data || issueque_imm !== mon_e.imm ||
                    issueque_opcode !== mon_e.opcode || issueque_rd_tag !== mon_e.rd_tag ||
                    (mon_e.opcode == OPC_SW && issueque_rt_data !== mon_e.rt_data)) begin
                    n_err++;
                    $display("FAIL issue_bundle: got op=%0d rd=%0d rs=%h rt=%h imm=%h, expected op=%0d rd=%0d rs=%h rt=%h imm=%h",
                             issueque_opcode, issueque_rd_tag, issueque_rs_data, issueque_rt_data, issueque_imm,
                             mon_e.opcode, mon_e.rd_tag, mon_e.rs_data, mon_e.rt_data, mon_e.imm);
                end else begin
                    $display("issue op=%0d rd=%0d rs=%h rt=%h imm=%h ok",
                             issueque_opcode, issueque_rd_tag, issueque_rs_data, issueque_rt_data, issueque_imm);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        dispatch_valid = 1'b0;
        cdb_valid      = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic drive_dispatch(input logic op, input logic [TW-1:0] rs_tag,
                                  input logic [DW-1:0] rs_data, input logic rs_v,
                                  input logic [TW-1:0] rt_tag, input logic [DW-1:0] rt_data,
                                  input logic rt_v, input logic [DW-1:0] imm,
                                  input logic [TW-1:0] rd);
        dispatch_valid    = 1'b1;
        dispatch_opcode   = op;
        dispatch_rs_tag   = rs_tag;
        dispatch_rs_data  = rs_data;
        dispatch_rs_valid = rs_v;
        dispatch_rt_tag   = rt_tag;
        dispatch_rt_data  = rt_data;
        dispatch_rt_valid = rt_v;
        dispatch_imm      = imm;
        dispatch_rd_tag   = rd;
    endtask

    task automatic push_exp(input logic op, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                            input logic [DW-1:0] imm, input logic [TW-1:0] rd);
        lsq_entry_t e;
        e = '0;
        e.opcode  = op;
        e.rs_data = rs;
        e.rt_data = rt;
        e.imm     = imm;
        e.rd_tag  = rd;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; drive_idle(); issue_grant = 1'b0;
        dispatch_opcode = 1'b0; dispatch_rs_tag = '0; dispatch_rs_data = '0;
        dispatch_rs_valid = 1'b0; dispatch_rt_tag = '0; dispatch_rt_data = '0;
        dispatch_rt_valid = 1'b0; dispatch_imm = '0; dispatch_rd_tag = '0;
        cdb_tag = '0; cdb_data = '0;
        tick(); tick();
        n_vec++;
        if (queue_full !== 1'b0 || issue_req !== 1'b0 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: full=%b req=%b done=%b, expected 0 0 0", queue_full, issue_req, issueblk_done);
        end
        n_vec++;
        if (issueque_rs_data !== '0 || issueque_rt_data !== '0 || issueque_imm !== '0 ||
            issueque_opcode !== 1'b0 || issueque_rd_tag !== '0) begin
            n_err++;
            $display("FAIL reset_bundle: rs=%h rt=%h imm=%h op=%b rd=%h, expected all 0",
                     issueque_rs_data, issueque_rt_data, issueque_imm, issueque_opcode, issueque_rd_tag);
        end
        rst_n = 1'b1;
        tick();
        $display("reset done");
    endtask

    task automatic test_basic_lw();
        issue_grant = 1'b1;
        drive_dispatch(OPC_LW, 6'd1, 32'h10, 1'b1, 6'd0, 32'h0, 1'b0, 32'h4, 6'd5);
        push_exp(OPC_LW, 32'h10, 32'h0, 32'h4, 6'd5);
        tick(); drive_idle();
        n_vec++;
        if (issue_req !== 1'b1 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_req: req=%b done=%b, expected 1 0", issue_req, issueblk_done);
        end
        tick();
        n_vec++;
        if (issueblk_done !== 1'b1 || issue_req !== 1'b0) begin
            n_err++;
            $display("FAIL basic_done: done=%b req=%b, expected 1 0", issueblk_done, issue_req);
        end
        tick();
        n_vec++;
        if (issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_pulse: done=%b, expected 0", issueblk_done);
        end
    endtask

    task automatic test_sw_cdb();
        issue_grant = 1'b1;
        drive_dispatch(OPC_SW, 6'd2, 32'h20, 1'b1, 6'd9, 32'h0, 1'b0, 32'h8, 6'd0);
        push_exp(OPC_SW, 32'h20, 32'hDEADBEEF, 32'h8, 6'd0);
        tick(); drive_idle();
        n_vec++;
        if (issue_req !== 1'b0) begin
            n_err++;
            $display("FAIL sw_wait1: req=%b, expected 0", issue_req);
        end
        tick();
        n_vec++;
        if (issue_req !== 1'b0) begin
            n_err++;
            $display("FAIL sw_wait2: req=%b, expected 0", issue_req);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEADBEEF;
        tick(); cdb_valid = 1'b0;
        n_vec++;
        if (issue_req !== 1'b1 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL sw_ready: req=%b done=%b, expected 1 0", issue_req, issueblk_done);
        end
        tick();
        n_vec++;
        if (issueblk_done !== 1'b1) begin
            n_err++;
            $display("FAIL sw_done: done=%b, expected 1", issueblk_done);
        end
        tick();
    endtask

    task automatic test_full_order();
        issue_grant = 1'b1;
        drive_dispatch(OPC_LW, 6'd12, 32'h0, 1'b0, 6'd0, 32'h0, 1'b0, 32'h0, 6'd1);
        push_exp(OPC_LW, 32'h1234, 32'h0, 32'h0, 6'd1);
        tick();
        drive_dispatch(OPC_LW, 6'd13, 32'h11, 1'b1, 6'd0, 32'h0, 1'b0, 32'h1, 6'd2);
        push_exp(OPC_LW, 32'h11, 32'h0, 32'h1, 6'd2);
        tick();
        drive_dispatch(OPC_SW, 6'd14, 32'h22, 1'b1, 6'd15, 32'h33, 1'b1, 32'h2, 6'd3);
        push_exp(OPC_SW, 32'h22, 32'h33, 32'h2, 6'd3);
        tick();
        drive_dispatch(OPC_LW, 6'd16, 32'h44, 1'b1, 6'd0, 32'h0, 1'b0, 32'h3, 6'd4);
        push_exp(OPC_LW, 32'h44, 32'h0, 32'h3, 6'd4);
        tick();
        n_vec++;
        if (queue_full !== 1'b1 || issue_req !== 1'b0) begin
            n_err++;
            $display("FAIL full_set: full=%b req=%b, expected 1 0", queue_full, issue_req);
        end
        drive_dispatch(OPC_LW, 6'd17, 32'h99, 1'b1, 6'd0, 32'h0, 1'b0, 32'h5, 6'h3F);
        tick(); drive_idle();
        n_vec++;
        if (queue_full !== 1'b1 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL full_drop: full=%b done=%b, expected 1 0", queue_full, issueblk_done);
        end
        tick();
        n_vec++;
        if (issue_req !== 1'b0 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL in_order_hold: req=%b done=%b, expected 0 0", issue_req, issueblk_done);
        end
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'h1234;
        tick(); cdb_valid = 1'b0;
        n_vec++;
        if (issue_req !== 1'b1) begin
            n_err++;
            $display("FAIL head_ready: req=%b, expected 1", issue_req);
        end
        for (int k = 0; k < DEPTH; k++) begin
            tick();
            n_vec++;
            if (issueblk_done !== 1'b1) begin
                n_err++;
                $display("FAIL burst_issue%0d: done=%b, expected 1", k, issueblk_done);
            end
        end
        tick();
        n_vec++;
        if (issueblk_done !== 1'b0 || sb.size() != 0 || queue_full !== 1'b0) begin
            n_err++;
            $display("FAIL burst_end: done=%b pending=%0d full=%b, expected 0 0 0",
                     issueblk_done, sb.size(), queue_full);
        end
    endtask

    task automatic test_bypass();
        issue_grant = 1'b1;
        drive_dispatch(OPC_LW, 6'd3, 32'hBAD, 1'b0, 6'd0, 32'h0, 1'b0, 32'h10, 6'd6);
        cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h55;
        push_exp(OPC_LW, 32'h55, 32'h0, 32'h10, 6'd6);
        tick(); drive_idle();
        n_vec++;
        if (issue_req !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_req: req=%b, expected 1", issue_req);
        end
        tick();
        n_vec++;
        if (issueblk_done !== 1'b1) begin
            n_err++;
            $display("FAIL bypass_done: done=%b, expected 1", issueblk_done);
        end
        tick();
    endtask

    task automatic test_flush();
        issue_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_dispatch(OPC_LW, 6'd20, 32'h70 + k, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'(k + 8));
            tick();
        end
        drive_idle();
        n_vec++;
        if (issue_req !== 1'b1 || queue_full !== 1'b0) begin
            n_err++;
            $display("FAIL flush_pre: req=%b full=%b, expected 1 0", issue_req, queue_full);
        end
        flush = 1'b1; issue_grant = 1'b1;
        drive_dispatch(OPC_LW, 6'd21, 32'h77, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'd11);
        tick(); drive_idle();
        n_vec++;
        if (issue_req !== 1'b0 || issueblk_done !== 1'b0 || queue_full !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: req=%b done=%b full=%b, expected 0 0 0",
                     issue_req, issueblk_done, queue_full);
        end
        tick();
        n_vec++;
        if (issue_req !== 1'b0 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after: req=%b done=%b, expected 0 0", issue_req, issueblk_done);
        end
        issue_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_dispatch(OPC_LW, 6'd22, 32'h80, 1'b1, 6'd0, 32'h0, 1'b0, 32'h0, 6'd12);
            tick();
        end
        drive_idle();
        n_vec++;
        if (queue_full !== 1'b0) begin
            n_err++;
            $display("FAIL flush_count: full=%b after 3 dispatches, expected 0", queue_full);
        end
        flush = 1'b1;
        tick(); drive_idle();
    endtask

    task automatic test_wrap_reset();
        issue_grant = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic op;
            op = (i % 2 == 1) ? OPC_SW : OPC_LW;
            drive_dispatch(op, 6'd30, 32'h100 + i, 1'b1, 6'd31, 32'h200 + i, 1'b1, 32'(i * 4), 6'(i + 1));
            push_exp(op, 32'h100 + i, 32'h200 + i, 32'(i * 4), 6'(i + 1));
            tick();
            n_vec++;
            if (issue_req !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_req%0d: req=%b, expected 1", i, issue_req);
            end
        end
        drive_idle();
        for (int k = 0; k < 10 && sb.size() != 0; k++) tick();
        tick();
        n_vec++;
        if (sb.size() != 0 || queue_full !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_drain: pending=%0d full=%b, expected 0 0", sb.size(), queue_full);
        end
        drive_dispatch(OPC_LW, 6'd40, 32'hA1, 1'b1, 6'd0, 32'h0, 1'b0, 32'h1, 6'd7);
        push_exp(OPC_LW, 32'hA1, 32'h0, 32'h1, 6'd7);
        tick();
        drive_dispatch(OPC_LW, 6'd41, 32'hA2, 1'b1, 6'd0, 32'h0, 1'b0, 32'h2, 6'd8);
        tick();
        n_vec++;
        if (issueblk_done !== 1'b1) begin
            n_err++;
            $display("FAIL midstream_done: done=%b, expected 1", issueblk_done);
        end
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (issueblk_done !== 1'b0 || issue_req !== 1'b0 || issueque_rs_data !== '0) begin
            n_err++;
            $display("FAIL midstream_reset: done=%b req=%b rs=%h, expected 0 0 0",
                     issueblk_done, issue_req, issueque_rs_data);
        end
        sb.delete();
        rst_n = 1'b1; drive_idle();
        tick();
        n_vec++;
        if (issue_req !== 1'b0 || issueblk_done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: req=%b done=%b, expected 0 0", issue_req, issueblk_done);
        end
    endtask

    initial begin
        test_reset();
        test_basic_lw();
        test_sw_cdb();
        test_full_order();
        test_bypass();
        test_flush();
        test_wrap_reset();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ld_st_issue_queue.md
Name: ld_st_issue_queue

Overview:
- In-order load/store issue queue feeding the memory execution unit.
- Accepts dispatched LW/SW instructions, holds them until their source operands are present, and snoops the CDB for missing operands by tag.
- Issues the oldest ready entry as a registered issue bundle (rs data, rt data, imm, opcode, rd tag, issueblk_done) when the CDB arbiter grants the memory slot.
- Strict program order, no load/store reordering. Sits between dispatch and the memory execution unit.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
TAG_WIDTH, 6, width of physical/ROB tags on dispatch and CDB
DATA_WIDTH, 32, operand and immediate width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
flush  in  1  branch-mispredict flush; empties queue
dispatch_valid  in  1  new LW/SW presented
dispatch_opcode  in  1  1=SW, 0=LW
dispatch_rs_tag  in  TAG_WIDTH  base-register producer tag
dispatch_rs_data  in  DATA_WIDTH  base-register value
dispatch_rs_valid  in  1  rs data already present
dispatch_rt_tag  in  TAG_WIDTH  store-data producer tag
dispatch_rt_data  in  DATA_WIDTH  store-data value
dispatch_rt_valid  in  1  rt data already present (ignored for LW)
dispatch_imm  in  DATA_WIDTH  sign-extended offset
dispatch_rd_tag  in  TAG_WIDTH  destination tag (LW)
queue_full  out  1  no free entry
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_WIDTH  CDB broadcast tag
cdb_data  in  DATA_WIDTH  CDB broadcast data
issue_req  out  1  head entry ready to issue
issue_grant  in  1  arbiter grants memory slot this cycle
issueblk_done  out  1  issue bundle valid (one-cycle pulse per issue)
issueque_rs_data  out  DATA_WIDTH  base register
issueque_rt_data  out  DATA_WIDTH  store data
issueque_imm  out  DATA_WIDTH  offset
issueque_opcode  out  1  1=SW, 0=LW
issueque_rd_tag  out  TAG_WIDTH  destination tag

Behaviour:
- Reset (rst_n=0 at posedge): head=tail=count=0, all entry valid bits 0, every issue output 0, queue_full=0, issue_req=0.
- Storage: circular buffer of DEPTH entries with head/tail pointers (log2 DEPTH bits, natural wrap) and a count of log2(DEPTH)+1 bits. queue_full = (count==DEPTH), combinational from registered count.
- Dispatch: accepted when dispatch_valid && !queue_full. The entry is written at tail and tail increments. With dispatch_valid && queue_full, nothing is written. The dispatcher must hold the instruction.
- Dispatch bypass: if an operand arrives not-valid and cdb_valid && cdb_tag matches its tag in the same cycle, the entry stores cdb_data with the operand marked valid.
- CDB snoop: every cycle, each valid entry with a not-ready rs (or rt) whose tag equals cdb_tag while cdb_valid captures cdb_data and sets ready. Multiple entries may match simultaneously; all capture.
- Readiness: ready = rs_ready && (opcode==LW || rt_ready). issue_req = head valid && head ready, combinational from registered state. CDB data captured this cycle does not make the entry ready until the next cycle.
- Issue: on posedge with issue_req && issue_grant:
  - the head entry is copied into the issueque_* registers;
  - issueblk_done is set for exactly the next cycle;
  - head increments and the entry valid bit clears.
  - Otherwise issueblk_done=0 and issueque_* hold their last values.
  - issue_grant without issue_req is ignored.
- Latency: dispatch with both operands valid at edge N gives issue_req in cycle N+1. A grant in N+1 gives issueblk_done high in cycle N+2. Minimum 2 cycles, sustained throughput 1 issue/cycle.
- Simultaneous dispatch + issue: both happen and count is unchanged. When full, dispatch is still refused in that cycle even if issue frees a slot. queue_full is registered-count based.
- Flush: synchronous, same effect as reset on queue state and issueblk_done. It overrides dispatch and issue in the same cycle. Reset has priority over flush.
- No reordering: a ready younger entry never issues ahead of a not-ready head.

Decomposition:
- Shared package (extend variables.sv) gets:
  - opcode encoding constants OPC_LW=0, OPC_SW=1;
  - TAG_WIDTH default;
  - lsq_entry_t struct (valid, opcode, rs_tag, rs_data, rs_ready, rt_tag, rt_data, rt_ready, imm, rd_tag).
- The issueque_* outputs and issueblk_done are packed into mem_data_exec_unit by the top level.
- One natural sub-module: lsq_operand_snoop (per-operand tag compare/capture against the CDB), instantiated 2×DEPTH.

Test Plan:
- Reset, then dispatch LW rs_valid=1 rs=0x10 imm=0x4 rd_tag=5, grant held high -> issue_req in cycle 2, issueblk_done pulse in cycle 3 with rs_data=0x10, imm=0x4, opcode=0, rd_tag=5.
- Dispatch SW rs ready=0x20, rt_valid=0 rt_tag=9; CDB tag=9 data=0xDEADBEEF two cycles later -> issue_req asserts the cycle after the broadcast, issued rt_data=0xDEADBEEF.
- Fill 4 entries with head not ready, 5th dispatch -> queue_full=1, 5th dropped. A younger ready entry never issues first. After the head's operand arrives, all 4 issue in order on 4 consecutive cycles.
- Dispatch operand tag=3 not-valid in the same cycle as CDB tag=3 data=0x55 -> entry captures 0x55 and issues without a further broadcast.
- Queue holding 3 entries, flush asserted together with dispatch_valid and issue_grant -> next cycle count=0, issue_req=0, issueblk_done=0.
- Tail wraps (DEPTH+2 dispatch/issue pairs) -> ordering and data correct across pointer wrap; rst_n low mid-stream clears issueblk_done on the next edge.
